// File: rtl/rv32i_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_lsu_if
//  Purpose  : Request/response and memory-port bundle for the rv32i LSU.
//             The slave view belongs to the LSU.
//             The master view belongs to whatever drives requests and
//             answers memory beats (core plus memory, or a testbench).
//  Revision : 1.0  initial release
// ============================================================================
interface rv32i_lsu_if #(
   parameter int ADDR_W = 32
) ();
   // core request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   // core response
   logic              rsp_valid;
   logic              rsp_error;
   logic [31:0]       rsp_rdata;
   // memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_error, rsp_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_error, rsp_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_lsu
//  Purpose  : Multi-cycle load/store unit.
//             It takes one request, drives word-aligned memory beats with
//             byte enables, and splits word-crossing accesses into two
//             beats.
//             It returns one extended/assembled response per request.
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_lsu #(
   parameter int ADDR_W         = 32,
   parameter int MISALIGN_SPLIT = 1,
   parameter int ACK_TIMEOUT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   rv32i_lsu_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state, state_next;
   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       asm_q;
   logic              rsp_error_q, err_next;
   logic [31:0]       rsp_rdata_q, rdata_next;
   logic              accept, timeout;

   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
      return (sz == 2'b01 && off == 2'd3) || (sz == 2'b10 && off != 2'd0);
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                          input logic uns);
      case (sz)
         2'b00:   return uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Lane geometry of the latched request: beat 0 shifts up by the byte
   // offset, beat 1 carries whatever spilled past lane 3.
   logic [1:0]        off;
   logic [4:0]        sh_lo;
   logic [5:0]        sh_hi;
   logic [7:0]        be_wide;
   logic              cross_q, in_beat;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       beat0_data, beat1_data;

   assign off        = addr_q[1:0];
   assign sh_lo      = {off, 3'b000};
   assign sh_hi      = 6'd32 - {1'b0, off, 3'b000};
   assign be_wide    = {4'b0000, size_mask(size_q)} << off;
   assign cross_q    = crosses(size_q, off);
   assign base_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign in_beat    = (state == BEAT0) || (state == BEAT1);
   assign beat0_data = bus.mem_rdata >> sh_lo;
   assign beat1_data = asm_q | (bus.mem_rdata << sh_hi);

   // Beat outputs come straight from state, so an async reset zeroes them
   // immediately and they cannot change while a beat waits for its ack.
   assign bus.req_ready = (state == IDLE);
   assign bus.mem_req   = in_beat;
   assign bus.mem_we    = in_beat & we_q;
   assign bus.mem_addr  = (state == BEAT0) ? base_addr :
                          (state == BEAT1) ? base_addr + ADDR_W'(4) : '0;
   assign bus.mem_be    = (state == BEAT0) ? be_wide[3:0] :
                          (state == BEAT1) ? be_wide[7:4] : 4'b0000;
   assign bus.mem_wdata = (state == BEAT0) ? (wdata_q << sh_lo) :
                          (state == BEAT1) ? (wdata_q >> sh_hi) : 32'd0;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_error = rsp_error_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   generate
      if (ACK_TIMEOUT > 0) begin : g_timeout
         localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
         logic [CNT_W-1:0] ack_wait;
         // Count unacknowledged cycles of the current beat; restart on ack or beat exit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                       ack_wait <= '0;
            else if (in_beat && !bus.mem_ack) ack_wait <= ack_wait + 1'b1;
            else                              ack_wait <= '0;
         end
         assign timeout = in_beat && !bus.mem_ack && (ack_wait == CNT_W'(ACK_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout = 1'b0;
      end
   endgenerate

   // State register plus the response fields computed on the way into RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         state       <= state_next;
         rsp_error_q <= err_next;
         rsp_rdata_q <= rdata_next;
      end
   end

   // Capture the request on accept and hold the low part of a split load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         asm_q   <= 32'd0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == BEAT0 && bus.mem_ack)
            asm_q <= beat0_data;
      end
   end

   // Next-state decode and response values for the transition into RESP.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      err_next   = 1'b0;
      rdata_next = 32'd0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               if (bus.req_size == 2'b11 ||
                   (MISALIGN_SPLIT == 0 && crosses(bus.req_size, bus.req_addr[1:0]))) begin
                  state_next = RESP;
                  err_next   = 1'b1;
               end else begin
                  state_next = BEAT0;
               end
            end
         end
         BEAT0: begin
            if (bus.mem_ack) begin
               if (cross_q) begin
                  state_next = BEAT1;
               end else begin
                  state_next = RESP;
                  if (!we_q) rdata_next = extend(beat0_data, size_q, uns_q);
               end
            end else if (timeout) begin
               state_next = RESP;
               err_next   = 1'b1;
            end
         end
         BEAT1: begin
            if (bus.mem_ack) begin
               state_next = RESP;
               if (!we_q) rdata_next = extend(beat1_data, size_q, uns_q);
            end else if (timeout) begin
               state_next = RESP;
               err_next   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_lsu
//  Purpose  : Self-checking bench for rv32i_lsu.
//             Table-driven zero-wait vectors run on the default build.
//             Hand sequences cover wait states, the no-split build, the
//             ack-timeout build and an async reset mid-beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_lsu;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rv32i_lsu_if #(.ADDR_W(32)) ifa ();
   rv32i_lsu_if #(.ADDR_W(32)) ifb ();
   rv32i_lsu_if #(.ADDR_W(32)) ifc ();

   rv32i_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(1), .ACK_TIMEOUT(0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   rv32i_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(0), .ACK_TIMEOUT(0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   rv32i_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(1), .ACK_TIMEOUT(4))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          nb;
      logic [31:0] rd0, rd1;
      logic [31:0] a0;  logic [3:0] be0; logic [31:0] wd0;
      logic [31:0] a1;  logic [3:0] be1; logic [31:0] wd1;
      logic [31:0] rsp;
      logic        err;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Zero-wait transaction on the default build, checking every beat and the response.
   task automatic run_vec(input int id, input vec_t v);
      @(negedge clk);
      chk($sformatf("v%0d req_ready", id), ifa.req_ready, 1);
      ifa.req_valid    = 1'b1;
      ifa.req_we       = v.we;
      ifa.req_size     = v.size;
      ifa.req_unsigned = v.uns;
      ifa.req_addr     = v.addr;
      ifa.req_wdata    = v.wdata;
      @(negedge clk);
      ifa.req_valid = 1'b0;
      ifa.req_addr  = 32'hDEAD_BEEF;
      ifa.req_wdata = 32'h5A5A_5A5A;
      ifa.req_size  = 2'b11;
      for (int b = 0; b < v.nb; b++) begin
         chk($sformatf("v%0d b%0d mem_req", id, b), ifa.mem_req, 1);
         chk($sformatf("v%0d b%0d mem_we", id, b), ifa.mem_we, v.we);
         chk($sformatf("v%0d b%0d mem_addr", id, b), ifa.mem_addr, b == 0 ? v.a0 : v.a1);
         chk($sformatf("v%0d b%0d mem_be", id, b), ifa.mem_be, b == 0 ? v.be0 : v.be1);
         chk($sformatf("v%0d b%0d mem_wdata", id, b), ifa.mem_wdata, b == 0 ? v.wd0 : v.wd1);
         ifa.mem_ack   = 1'b1;
         ifa.mem_rdata = (b == 0) ? v.rd0 : v.rd1;
         @(negedge clk);
         ifa.mem_ack   = 1'b0;
         ifa.mem_rdata = 32'h0;
      end
      chk($sformatf("v%0d mem_req_at_rsp", id), ifa.mem_req, 0);
      chk($sformatf("v%0d rsp_valid", id), ifa.rsp_valid, 1);
      chk($sformatf("v%0d rsp_error", id), ifa.rsp_error, v.err);
      chk($sformatf("v%0d rsp_rdata", id), ifa.rsp_rdata, v.rsp);
      @(negedge clk);
      chk($sformatf("v%0d rsp_pulse_end", id), ifa.rsp_valid, 0);
   endtask

   task automatic clear_inputs();
      ifa.req_valid = 0; ifa.req_we = 0; ifa.req_size = 0; ifa.req_unsigned = 0;
      ifa.req_addr = 0;  ifa.req_wdata = 0; ifa.mem_ack = 0; ifa.mem_rdata = 0;
      ifb.req_valid = 0; ifb.req_we = 0; ifb.req_size = 0; ifb.req_unsigned = 0;
      ifb.req_addr = 0;  ifb.req_wdata = 0; ifb.mem_ack = 0; ifb.mem_rdata = 0;
      ifc.req_valid = 0; ifc.req_we = 0; ifc.req_size = 0; ifc.req_unsigned = 0;
      ifc.req_addr = 0;  ifc.req_wdata = 0; ifc.mem_ack = 0; ifc.mem_rdata = 0;
   endtask

   initial begin
      int hi;
      logic got;

      // Fields: we size uns addr wdata nb rd0 rd1 | a0 be0 wd0 | a1 be1 wd1 | rsp err
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'h800000F0, 32'h0,
                   32'h100, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h800000F0, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00000080, 1'b0};
      vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 2, 32'h0, 32'h0,
                   32'h100, 4'b1100, 32'h33440000, 32'h104, 4'b0011, 32'h00001122, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 2, 32'hBBAA0000, 32'h0000DDCC,
                   32'hFFFFFFFC, 4'b1100, 32'h0, 32'h0, 4'b0011, 32'h0, 32'hDDCCBBAA, 1'b0};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1, 32'h12F0AB34, 32'h0,
                   32'h100, 4'b0110, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFF0AB, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 2, 32'hCD000000, 32'h000000EF,
                   32'h100, 4'b1000, 32'h0, 32'h104, 4'b0001, 32'h0, 32'h0000EFCD, 1'b0};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5, 1, 32'h0, 32'h0,
                   32'h200, 4'b0010, 32'h0000A500, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF, 1, 32'h0, 32'h0,
                   32'h300, 4'b1100, 32'hBEEF0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 0, 32'h0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1, 32'h12348001, 32'h0,
                   32'h100, 4'b0011, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h107, 32'hAABBCCDD, 2, 32'h0, 32'h0,
                   32'h104, 4'b1000, 32'hDD000000, 32'h108, 4'b0111, 32'h00AABBCC, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1, 32'h00550000, 32'h0,
                   32'h100, 4'b0100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00000055, 1'b0};
      vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1, 32'hF00D0000, 32'h0,
                   32'h100, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0000F00D, 1'b0};

      clear_inputs();
      rst_n = 1'b0;
      #3;
      chk("reset req_ready", ifa.req_ready, 1);
      chk("reset mem_req", ifa.mem_req, 0);
      chk("reset mem_be", ifa.mem_be, 0);
      chk("reset mem_addr", ifa.mem_addr, 0);
      chk("reset mem_wdata", ifa.mem_wdata, 0);
      chk("reset rsp_valid", ifa.rsp_valid, 0);
      chk("reset rsp_error", ifa.rsp_error, 0);
      chk("reset rsp_rdata", ifa.rsp_rdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // mem_ack while idle must not start anything.
      @(negedge clk);
      ifa.mem_ack = 1'b1;
      @(negedge clk);
      ifa.mem_ack = 1'b0;
      chk("stray ack req_ready", ifa.req_ready, 1);
      chk("stray ack rsp_valid", ifa.rsp_valid, 0);

      // Wait states: beat outputs hold steady until the ack.
      ifa.req_valid = 1; ifa.req_we = 0; ifa.req_size = 2'b10; ifa.req_unsigned = 0;
      ifa.req_addr = 32'h10;
      @(negedge clk);
      ifa.req_valid = 0;
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("wait%0d mem_req", w), ifa.mem_req, 1);
         chk($sformatf("wait%0d mem_addr", w), ifa.mem_addr, 32'h10);
         chk($sformatf("wait%0d mem_be", w), ifa.mem_be, 4'b1111);
         chk($sformatf("wait%0d rsp_valid", w), ifa.rsp_valid, 0);
         @(negedge clk);
      end
      ifa.mem_ack = 1; ifa.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      ifa.mem_ack = 0;
      chk("wait rsp_valid", ifa.rsp_valid, 1);
      chk("wait rsp_rdata", ifa.rsp_rdata, 32'hCAFEF00D);

      // No-split build: crossing word load is rejected without a beat;
      // the error path skips the beat states, so it responds one cycle after accept.
      @(negedge clk);
      ifb.req_valid = 1; ifb.req_we = 0; ifb.req_size = 2'b10; ifb.req_addr = 32'h101;
      @(negedge clk);
      ifb.req_valid = 0;
      chk("nosplit mem_req", ifb.mem_req, 0);
      chk("nosplit rsp_valid", ifb.rsp_valid, 1);
      chk("nosplit rsp_error", ifb.rsp_error, 1);
      chk("nosplit rsp_rdata", ifb.rsp_rdata, 0);
      // Half at offset 1 stays inside the word, so it still goes through.
      @(negedge clk);
      ifb.req_valid = 1; ifb.req_size = 2'b01; ifb.req_addr = 32'h101;
      @(negedge clk);
      ifb.req_valid = 0;
      chk("nosplit lh mem_req", ifb.mem_req, 1);
      chk("nosplit lh mem_be", ifb.mem_be, 4'b0110);
      ifb.mem_ack = 1; ifb.mem_rdata = 32'h00BEEF00;
      @(negedge clk);
      ifb.mem_ack = 0;
      chk("nosplit lh rsp_error", ifb.rsp_error, 0);
      chk("nosplit lh rsp_rdata", ifb.rsp_rdata, 32'hFFFFBEEF);

      // Timeout build: no ack ever, mem_req high for exactly 4 cycles.
      @(negedge clk);
      ifc.req_valid = 1; ifc.req_we = 0; ifc.req_size = 2'b10; ifc.req_addr = 32'h20;
      hi = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         ifc.req_valid = 0;
         if (ifc.rsp_valid) begin
            got = 1'b1;
            chk("timeout mem_req_at_rsp", ifc.mem_req, 0);
            chk("timeout rsp_error", ifc.rsp_error, 1);
            chk("timeout rsp_rdata", ifc.rsp_rdata, 0);
         end else if (ifc.mem_req) begin
            hi++;
         end
      end
      chk("timeout rsp seen", got, 1);
      chk("timeout mem_req cycles", hi, 4);

      // Async reset in the middle of a beat.
      @(negedge clk);
      ifa.req_valid = 1; ifa.req_size = 2'b10; ifa.req_addr = 32'h30;
      @(negedge clk);
      ifa.req_valid = 0;
      chk("midbeat mem_req before", ifa.mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midbeat mem_req async", ifa.mem_req, 0);
      chk("midbeat req_ready async", ifa.req_ready, 1);
      chk("midbeat mem_addr async", ifa.mem_addr, 0);
      chk("midbeat mem_be async", ifa.mem_be, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post reset mem_req", ifa.mem_req, 0);
      chk("post reset rsp_valid", ifa.rsp_valid, 0);
      chk("post reset req_ready", ifa.req_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
